// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decode of R/I/S/B/U/J formats into a registered
// payload, with a one-entry skid register so in_ready comes straight from a flop.
module decode_stage #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [31:0]                 in_instr,
  input  logic [XLEN-1:0]             in_pc,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [XLEN-1:0]             out_pc,
  output logic [2:0]                  out_fmt,
  output logic [6:0]                  out_opcode,
  output logic [2:0]                  out_funct3,
  output logic [6:0]                  out_funct7,
  output logic [$clog2(NUM_REGS)-1:0] out_rd,
  output logic [$clog2(NUM_REGS)-1:0] out_rs1,
  output logic [$clog2(NUM_REGS)-1:0] out_rs2,
  output logic                        out_rd_we,
  output logic                        out_rs1_en,
  output logic                        out_rs2_en,
  output logic [XLEN-1:0]             out_imm,
  output logic                        out_illegal
);

  localparam int RA_W = $clog2(NUM_REGS);
  localparam logic [5:0] NREGS = 6'(NUM_REGS);

  localparam logic [2:0] FMT_R    = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_NONE = 3'd7;

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_JLR = 7'b1100111;
  localparam logic [6:0] OP_REG = 7'b0110011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [2:0]      fmt;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [RA_W-1:0] rd;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic            rd_we;
    logic            rs1_en;
    logic            rs2_en;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } payload_t;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  logic [6:0]  w_op;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [4:0]  w_rd;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [2:0]  w_fmt;
  logic        w_bad;
  logic        w_use_rs1;
  logic        w_use_rs2;
  logic        w_use_rd;
  logic [31:0] w_imm32;
  logic        w_in_fire;
  payload_t    w_dec;

  state_t      r_state;
  logic        r_in_ready;
  logic        r_out_valid;
  payload_t    r_main;
  payload_t    r_skid;

  assign w_op  = in_instr[6:0];
  assign w_f3  = in_instr[14:12];
  assign w_f7  = in_instr[31:25];
  assign w_rd  = in_instr[11:7];
  assign w_rs1 = in_instr[19:15];
  assign w_rs2 = in_instr[24:20];

  always_comb begin
    w_fmt = FMT_NONE;
    case (w_op)
      OP_IMM, OP_LD, OP_JLR: w_fmt = FMT_I;
      OP_REG:                w_fmt = FMT_R;
      OP_ST:                 w_fmt = FMT_S;
      OP_BR:                 w_fmt = FMT_B;
      OP_LUI, OP_AUI:        w_fmt = FMT_U;
      OP_JAL:                w_fmt = FMT_J;
      default:               w_fmt = FMT_NONE;
    endcase

    w_use_rs1 = (w_fmt == FMT_R) || (w_fmt == FMT_I) || (w_fmt == FMT_S) || (w_fmt == FMT_B);
    w_use_rs2 = (w_fmt == FMT_R) || (w_fmt == FMT_S) || (w_fmt == FMT_B);
    w_use_rd  = (w_fmt == FMT_R) || (w_fmt == FMT_I) || (w_fmt == FMT_U) || (w_fmt == FMT_J);

    w_bad = (in_instr[1:0] != 2'b11) || (w_fmt == FMT_NONE);
    if (w_op == OP_REG) begin
      if ((w_f7 != 7'h00) && (w_f7 != 7'h20)) w_bad = 1'b1;
      if ((w_f7 == 7'h20) && (w_f3 != 3'd0) && (w_f3 != 3'd5)) w_bad = 1'b1;
    end
    if (w_op == OP_IMM) begin
      if ((w_f3 == 3'd1) && (w_f7 != 7'h00)) w_bad = 1'b1;
      if ((w_f3 == 3'd5) && (w_f7 != 7'h00) && (w_f7 != 7'h20)) w_bad = 1'b1;
    end
    // RV32E-style configs: any referenced register outside the file is illegal
    if (w_use_rs1 && ({1'b0, w_rs1} >= NREGS)) w_bad = 1'b1;
    if (w_use_rs2 && ({1'b0, w_rs2} >= NREGS)) w_bad = 1'b1;
    if (w_use_rd  && ({1'b0, w_rd}  >= NREGS)) w_bad = 1'b1;

    case (w_fmt)
      FMT_I:   w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      FMT_S:   w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      FMT_B:   w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                          in_instr[11:8], 1'b0};
      FMT_U:   w_imm32 = {in_instr[31:12], 12'h000};
      FMT_J:   w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                          in_instr[30:21], 1'b0};
      default: w_imm32 = 32'h0;
    endcase

    w_dec         = '0;
    w_dec.pc      = in_pc;
    w_dec.opcode  = w_op;
    w_dec.funct3  = w_f3;
    w_dec.funct7  = w_f7;
    w_dec.rd      = w_rd[RA_W-1:0];
    w_dec.rs1     = w_rs1[RA_W-1:0];
    w_dec.rs2     = w_rs2[RA_W-1:0];
    if (w_bad) begin
      w_dec.fmt     = FMT_NONE;
      w_dec.illegal = 1'b1;
    end else begin
      w_dec.fmt     = w_fmt;
      w_dec.rd_we   = w_use_rd && (w_rd != 5'd0);
      w_dec.rs1_en  = w_use_rs1;
      w_dec.rs2_en  = w_use_rs2;
      w_dec.imm     = XLEN'($signed(w_imm32));
    end
  end

  assign w_in_fire = in_valid && r_in_ready;

  // Main register always holds the oldest entry; skid only fills when main stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_main      <= '0;
      r_skid      <= '0;
    end else if (flush) begin
      r_state     <= S_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_in_fire) begin
            r_main      <= w_dec;
            r_state     <= S_ONE;
            r_out_valid <= 1'b1;
          end
        end
        S_ONE: begin
          if (w_in_fire && out_ready) begin
            r_main <= w_dec;
          end else if (w_in_fire) begin
            r_skid     <= w_dec;
            r_state    <= S_TWO;
            r_in_ready <= 1'b0;
          end else if (out_ready) begin
            r_state     <= S_EMPTY;
            r_out_valid <= 1'b0;
          end
        end
        S_TWO: begin
          if (out_ready) begin
            r_main     <= r_skid;
            r_state    <= S_ONE;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_pc      = r_main.pc;
  assign out_fmt     = r_main.fmt;
  assign out_opcode  = r_main.opcode;
  assign out_funct3  = r_main.funct3;
  assign out_funct7  = r_main.funct7;
  assign out_rd      = r_main.rd;
  assign out_rs1     = r_main.rs1;
  assign out_rs2     = r_main.rs2;
  assign out_rd_we   = r_main.rd_we;
  assign out_rs1_en  = r_main.rs1_en;
  assign out_rs2_en  = r_main.rs2_en;
  assign out_imm     = r_main.imm;
  assign out_illegal = r_main.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: an RV32I (32-reg) and an RV32E (16-reg) instance run
// in lockstep; expected payloads come from an arithmetic reference decoder.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = 32'h0;
  logic [31:0] in_pc = 32'h0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, out_rd_we, out_rs1_en, out_rs2_en, out_illegal;
  logic [31:0] out_pc, out_imm;
  logic [2:0]  out_fmt, out_funct3;
  logic [6:0]  out_opcode, out_funct7;
  logic [4:0]  out_rd, out_rs1, out_rs2;

  logic        e_in_ready, e_out_valid, e_rd_we, e_rs1_en, e_rs2_en, e_illegal;
  logic [31:0] e_pc, e_imm;
  logic [2:0]  e_fmt, e_funct3;
  logic [6:0]  e_opcode, e_funct7;
  logic [3:0]  e_rd, e_rs1, e_rs2;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .NUM_REGS(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_fmt(out_fmt), .out_opcode(out_opcode), .out_funct3(out_funct3),
    .out_funct7(out_funct7), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_rd_we(out_rd_we), .out_rs1_en(out_rs1_en), .out_rs2_en(out_rs2_en),
    .out_imm(out_imm), .out_illegal(out_illegal));

  decode_stage #(.XLEN(32), .NUM_REGS(16)) u_e (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(e_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(e_out_valid), .out_ready(out_ready),
    .out_pc(e_pc), .out_fmt(e_fmt), .out_opcode(e_opcode), .out_funct3(e_funct3),
    .out_funct7(e_funct7), .out_rd(e_rd), .out_rs1(e_rs1), .out_rs2(e_rs2),
    .out_rd_we(e_rd_we), .out_rs1_en(e_rs1_en), .out_rs2_en(e_rs2_en),
    .out_imm(e_imm), .out_illegal(e_illegal));

  typedef struct {
    logic [31:0] pc;
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd, rs1, rs2;
    logic        we, en1, en2;
    logic [31:0] imm;
    logic        ill;
  } exp_t;

  int n_pass = 0;
  int n_total = 0;
  logic rnd_rdy = 1'b0;
  logic mon_en = 1'b0;
  logic [127:0] q32[$];
  logic [127:0] q16[$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference decoder: formats from the opcode table, immediates by signed arithmetic
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc, input int nregs);
    exp_t x;
    int si;
    int imm;
    logic bad, u1, u2, ud;
    si = $signed(ins);
    x.pc = pc; x.op = ins[6:0]; x.f3 = ins[14:12]; x.f7 = ins[31:25];
    x.rd = ins[11:7]; x.rs1 = ins[19:15]; x.rs2 = ins[24:20];
    bad = 1'b0;
    case (x.op)
      7'h13, 7'h03, 7'h67: x.fmt = 3'd1;
      7'h33:               x.fmt = 3'd0;
      7'h23:               x.fmt = 3'd2;
      7'h63:               x.fmt = 3'd3;
      7'h37, 7'h17:        x.fmt = 3'd4;
      7'h6f:               x.fmt = 3'd5;
      default: begin x.fmt = 3'd7; bad = 1'b1; end
    endcase
    if (ins[1:0] != 2'b11) bad = 1'b1;
    if (x.op == 7'h33 && !(x.f7 == 7'h00 || (x.f7 == 7'h20 && (x.f3 == 3'd0 || x.f3 == 3'd5))))
      bad = 1'b1;
    if (x.op == 7'h13 && x.f3 == 3'd1 && x.f7 != 7'h00) bad = 1'b1;
    if (x.op == 7'h13 && x.f3 == 3'd5 && !(x.f7 == 7'h00 || x.f7 == 7'h20)) bad = 1'b1;
    u1 = (x.fmt <= 3'd3);
    u2 = (x.fmt == 3'd0 || x.fmt == 3'd2 || x.fmt == 3'd3);
    ud = (x.fmt == 3'd0 || x.fmt == 3'd1 || x.fmt == 3'd4 || x.fmt == 3'd5);
    if ((u1 && int'(x.rs1) >= nregs) || (u2 && int'(x.rs2) >= nregs) || (ud && int'(x.rd) >= nregs))
      bad = 1'b1;
    case (x.fmt)
      3'd1: imm = si >>> 20;
      3'd2: imm = (si >>> 25) * 32 + int'(ins[11:7]);
      3'd3: imm = (si >>> 31) * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
      3'd4: imm = $signed(ins & 32'hFFFFF000);
      3'd5: imm = (si >>> 31) * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
      default: imm = 0;
    endcase
    if (bad) begin
      x.fmt = 3'd7; x.we = 1'b0; x.en1 = 1'b0; x.en2 = 1'b0; x.imm = 32'h0; x.ill = 1'b1;
    end else begin
      x.we = ud && (x.rd != 5'd0); x.en1 = u1; x.en2 = u2; x.imm = imm; x.ill = 1'b0;
    end
    return x;
  endfunction

  function automatic logic [127:0] pack32(input exp_t x);
    return 128'({x.pc, x.fmt, x.op, x.f3, x.f7, x.rd, x.rs1, x.rs2, x.we, x.en1, x.en2, x.imm, x.ill});
  endfunction

  function automatic logic [127:0] pack16(input exp_t x);
    return 128'({x.pc, x.fmt, x.op, x.f3, x.f7, x.rd[3:0], x.rs1[3:0], x.rs2[3:0],
                 x.we, x.en1, x.en2, x.imm, x.ill});
  endfunction

  logic [127:0] w_act32, w_act16;
  assign w_act32 = 128'({out_pc, out_fmt, out_opcode, out_funct3, out_funct7, out_rd, out_rs1,
                         out_rs2, out_rd_we, out_rs1_en, out_rs2_en, out_imm, out_illegal});
  assign w_act16 = 128'({e_pc, e_fmt, e_opcode, e_funct3, e_funct7, e_rd, e_rs1, e_rs2,
                         e_rd_we, e_rs1_en, e_rs2_en, e_imm, e_illegal});

  // Monitor: pops on every output transfer, and checks payload holds under back-pressure
  logic         have_prev = 1'b0;
  logic [127:0] prev32, prev16;
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      chk("lockstep", 128'({e_in_ready, e_out_valid}), 128'({in_ready, out_valid}));
      if (have_prev && out_valid) begin
        chk("stable32", w_act32, prev32);
        chk("stable16", w_act16, prev16);
      end
      have_prev = out_valid && !out_ready && !flush;
      prev32 = w_act32;
      prev16 = w_act16;
      if (out_valid && out_ready && !flush) begin
        if (q32.size() == 0) begin
          chk("unexpected_out", 128'(1), 128'(0));
        end else begin
          chk("payload32", w_act32, q32.pop_front());
          chk("payload16", w_act16, q16.pop_front());
        end
      end
    end else begin
      have_prev = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic push(input logic [31:0] ins, input logic [31:0] pc);
    q32.push_back(pack32(model(ins, pc, 32)));
    q16.push_back(pack16(model(ins, pc, 16)));
  endtask

  task automatic send(input logic [31:0] ins, input logic [31:0] pc);
    logic ok;
    ok = 1'b0;
    in_valid = 1'b1; in_instr = ins; in_pc = pc;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      if (in_ready) begin
        push(ins, pc);
        ok = 1'b1;
      end
      step();
    end
    if (!ok) chk("send_accept", 128'(0), 128'(1));
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] gen();
    logic [31:0] w;
    logic [6:0] ops [9];
    int k;
    ops = '{7'h13, 7'h03, 7'h67, 7'h33, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f};
    w = $urandom;
    k = $urandom_range(0, 11);
    if (k < 9) w[6:0] = ops[k];
    else if (k == 10) begin
      w[6:0] = 7'h33;
      w[31:25] = ($urandom_range(0, 2) == 0) ? 7'(w[31:25]) : ($urandom_range(0, 1) ? 7'h20 : 7'h00);
    end else if (k == 11) begin
      w[6:0] = 7'h13;
      w[14:12] = $urandom_range(0, 1) ? 3'd1 : 3'd5;
      if ($urandom_range(0, 2) != 0) w[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00;
    end
    if (k == 3 && $urandom_range(0, 1) == 1) w[31:25] = 7'h00;
    return w;
  endfunction

  initial begin
    // reset values
    #23;
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_payload", w_act32, 128'(0));
    rst_n = 1'b1;
    mon_en = 1'b1;
    step();

    // directed decodes, out_ready held high
    out_ready = 1'b1;
    send(32'hFFF00093, 32'h0000_0100);
    @(negedge clk);
    chk("addi_valid", 128'(out_valid), 128'(1));
    chk("addi_fields", 128'({out_fmt, out_rd, out_rs1, out_rd_we, out_rs2_en}),
        128'({3'd1, 5'd1, 5'd0, 1'b1, 1'b0}));
    chk("addi_imm", 128'(out_imm), 128'(32'hFFFFFFFF));
    step();
    send(32'hFE208EE3, 32'h0000_0104);
    @(negedge clk);
    chk("beq_fields", 128'({out_fmt, out_rs1, out_rs2, out_rd_we}), 128'({3'd3, 5'd1, 5'd2, 1'b0}));
    chk("beq_imm", 128'(out_imm), 128'(32'hFFFFFFFC));
    step();
    send(32'h001000EF, 32'h0000_0108);
    @(negedge clk);
    chk("jal_fields", 128'({out_fmt, out_rd, out_rs1_en}), 128'({3'd5, 5'd1, 1'b0}));
    chk("jal_imm", 128'(out_imm), 128'(32'h00000800));
    step();
    send(32'h00000000, 32'h0000_010C);
    @(negedge clk);
    chk("zero_illegal", 128'({out_illegal, out_fmt, out_rd_we, out_rs1_en, out_rs2_en, out_imm}),
        128'({1'b1, 3'd7, 3'b000, 32'h0}));
    step();
    send(32'h00208833, 32'h0000_0110);
    @(negedge clk);
    chk("add_x16_rv32e", 128'({e_illegal, e_fmt}), 128'({1'b1, 3'd7}));
    chk("add_x16_rv32i", 128'({out_illegal, out_fmt, out_rd_we}), 128'({1'b0, 3'd0, 1'b1}));
    for (int i = 0; i < 3; i++) step();

    // back-pressure: A and B accepted, C blocked until the skid drains
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00500113; in_pc = 32'h200;
    @(negedge clk); chk("bp_a_ready", 128'(in_ready), 128'(1)); push(in_instr, in_pc);
    step();
    in_instr = 32'h00A00193; in_pc = 32'h204;
    @(negedge clk); chk("bp_b_ready", 128'(in_ready), 128'(1)); push(in_instr, in_pc);
    step();
    in_instr = 32'h003100B3; in_pc = 32'h208;
    @(negedge clk); chk("bp_c_blocked", 128'(in_ready), 128'(0));
    step();
    @(negedge clk); chk("bp_c_still_blocked", 128'(in_ready), 128'(0));
    step();
    out_ready = 1'b1;
    send(32'h003100B3, 32'h208);
    for (int i = 0; i < 4; i++) step();
    chk("bp_drained", 128'(q32.size()), 128'(0));

    // flush while full, with a simultaneous input that must be discarded
    out_ready = 1'b0;
    send(32'h00100093, 32'h300);
    send(32'h00200113, 32'h304);
    in_valid = 1'b1; in_instr = 32'h00300193; in_pc = 32'h308;
    flush = 1'b1;
    @(negedge clk); chk("flush_in_two", 128'(in_ready), 128'(0));
    step();
    flush = 1'b0; in_valid = 1'b0;
    q32.delete(); q16.delete();
    @(negedge clk);
    chk("flush_out_valid", 128'(out_valid), 128'(0));
    chk("flush_in_ready", 128'(in_ready), 128'(1));
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      @(negedge clk);
      chk("flush_no_emit", 128'(out_valid), 128'(0));
    end
    step();

    // randomized traffic with random back-pressure
    rnd_rdy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      send(gen(), {$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
      if ($urandom_range(0, 3) == 0) step();
    end
    rnd_rdy = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && q32.size() != 0; i++) step();
    chk("random_drained", 128'(q32.size()), 128'(0));

    // asynchronous reset while holding two entries
    out_ready = 1'b0;
    send(32'h00100093, 32'h400);
    send(32'h00200113, 32'h404);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 128'({out_valid, e_out_valid}), 128'(0));
    chk("async_rst_ready", 128'({in_ready, e_in_ready}), 128'({1'b1, 1'b1}));
    q32.delete(); q16.delete();
    #20;
    rst_n = 1'b1;
    step();
    @(negedge clk);
    chk("post_rst_idle", 128'(out_valid), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
